// File: rtl/cdm_pkg.sv
// Shared types and widths for the carry-disregard multiplier (cdm) blocks.
package cdm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } cdm_state_t;

    localparam int CDM_PROD_W = 32;

    // |a - b| of two unsigned prod_w-bit values always fits in prod_w bits.
    function automatic int ed_width(input int prod_w);
        return prod_w;
    endfunction

    // Accumulating 2^log2_n errors of prod_w bits each never exceeds prod_w + log2_n bits.
    function automatic int sum_width(input int prod_w, input int log2_n);
        return prod_w + log2_n;
    endfunction

endpackage

// File: rtl/cdm_abs_diff.sv
// Combinational unsigned error distance |a - b| between two cdm products.
module cdm_abs_diff
    import cdm_pkg::*;
#(
    parameter int W = CDM_PROD_W
) (
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    output logic [ed_width(W)-1:0] ed
);

    logic [W:0] diff;

    // The extra top bit of the difference is the borrow, i.e. the sign of a - b.
    assign diff = {1'b0, a} - {1'b0, b};
    assign ed   = diff[W] ? (~diff[W-1:0] + W'(1)) : diff[W-1:0];

endmodule

// File: rtl/cdm_error_monitor.sv
// Collects error-distance statistics (sum, mean, worst case, error count) over a
// run of 2^LOG2_N (approximate, exact) product pairs from a cdm multiplier.
module cdm_error_monitor
    import cdm_pkg::*;
#(
    parameter int LOG2_N = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CDM_PROD_W-1:0]        approx,
    input  logic [CDM_PROD_W-1:0]        exact,
    output logic                         busy,
    output logic                         done,
    output logic [CDM_PROD_W+LOG2_N-1:0] sum_ed,
    output logic [CDM_PROD_W-1:0]        med,
    output logic [CDM_PROD_W-1:0]        wce,
    output logic [LOG2_N:0]              err_count
);

    localparam int ED_W  = ed_width(CDM_PROD_W);
    localparam int SUM_W = sum_width(CDM_PROD_W, LOG2_N);
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = {1'b0, {LOG2_N{1'b1}}};

    cdm_state_t       state;
    logic [CNT_W-1:0] sample_cnt;
    logic             handshake;
    logic             clear_acc;
    logic [ED_W-1:0]  ed;
    logic             s1_valid;
    logic [ED_W-1:0]  s1_ed;

    assign handshake = in_valid && in_ready;
    assign clear_acc = start && ((state == IDLE) || (state == DONE));

    cdm_abs_diff #(
        .W (CDM_PROD_W)
    ) u_abs_diff (
        .a  (approx),
        .b  (exact),
        .ed (ed)
    );

    // Control FSM; in_ready/busy/done are registered alongside the state so
    // they always agree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sample_cnt <= '0;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (sample_cnt == CNT_LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 captures the error distance of each accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else begin
            s1_valid <= handshake;
            if (handshake) begin
                s1_ed <= ed;
            end
        end
    end

    // Stage 2 folds the captured error into the run statistics; a new run
    // clears them (no stage-1 sample can be pending when a run starts).
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_ed    <= '0;
            wce       <= '0;
            err_count <= '0;
        end else if (clear_acc) begin
            sum_ed    <= '0;
            wce       <= '0;
            err_count <= '0;
        end else if (s1_valid) begin
            sum_ed    <= sum_ed + SUM_W'(s1_ed);
            wce       <= (s1_ed > wce) ? s1_ed : wce;
            err_count <= err_count + CNT_W'(s1_ed != '0);
        end
    end

    assign med = sum_ed[LOG2_N +: CDM_PROD_W];

endmodule

// File: tb/tb_cdm_error_monitor.sv
// Randomized self-checking bench for cdm_error_monitor against a queue-based
// reference model; a second, wider instance checks the no-overflow corner.
module tb_cdm_error_monitor;

    localparam int LN  = 2;
    localparam int N   = 4;
    localparam int BLN = 12;
    localparam int BN  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] approx;
    logic [31:0] exact;
    logic        busy;
    logic        done;
    logic [33:0] sum_ed;
    logic [31:0] med;
    logic [31:0] wce;
    logic [2:0]  err_count;

    logic        start_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [31:0] approx_b;
    logic [31:0] exact_b;
    logic        busy_b;
    logic        done_b;
    logic [43:0] sum_ed_b;
    logic [31:0] med_b;
    logic [31:0] wce_b;
    logic [12:0] err_count_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sa [N];
    logic [31:0] se [N];

    always #5 clk = ~clk;

    cdm_error_monitor #(.LOG2_N(LN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .approx    (approx),
        .exact     (exact),
        .busy      (busy),
        .done      (done),
        .sum_ed    (sum_ed),
        .med       (med),
        .wce       (wce),
        .err_count (err_count)
    );

    cdm_error_monitor #(.LOG2_N(BLN)) dut_big (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .approx    (approx_b),
        .exact     (exact_b),
        .busy      (busy_b),
        .done      (done_b),
        .sum_ed    (sum_ed_b),
        .med       (med_b),
        .wce       (wce_b),
        .err_count (err_count_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned refEd(input logic [31:0] a, input logic [31:0] e);
        longint unsigned la = 64'(a);
        longint unsigned le = 64'(e);
        return (la >= le) ? (la - le) : (le - la);
    endfunction

    task automatic fillSamples(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: begin
                    sa[i] = $urandom;
                    se[i] = sa[i];
                end
                1: begin
                    sa[i] = $urandom;
                    se[i] = sa[i] + 32'($urandom_range(0, 6)) - 32'd3;
                end
                2: begin
                    sa[i] = $urandom;
                    se[i] = $urandom;
                end
                default: begin
                    sa[i] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
                    se[i] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
                end
            endcase
        end
    endtask

    // One run on the small instance. mode: 0 back-to-back, 1 every other cycle,
    // 2 random gaps. Optionally pulses start mid-run or resets during DRAIN.
    task automatic applyStimulus(input int mode, input bit mid_start, input bit rst_drain);
        longint unsigned ed_q[$];
        int              hs_edge[$];
        longint unsigned vis;
        longint unsigned e_sum;
        longint unsigned e_wce;
        int              e_err;
        int              idx;
        int              edge_no;
        bit              hs;
        bit              mid_done;

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_busy", 64'(busy), 64'd1);
        checkOutput("start_ready", 64'(in_ready), 64'd1);
        checkOutput("start_done", 64'(done), 64'd0);
        checkOutput("start_sum", 64'(sum_ed), 64'd0);
        checkOutput("start_wce", 64'(wce), 64'd0);
        checkOutput("start_err", 64'(err_count), 64'd0);

        idx      = 0;
        edge_no  = 0;
        mid_done = 1'b0;
        while (idx < N && edge_no < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (edge_no % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            approx = sa[idx];
            exact  = se[idx];
            if (mid_start && !mid_done && idx == 2) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            hs = in_valid && in_ready;
            tick();
            edge_no++;
            start = 1'b0;
            if (hs) begin
                ed_q.push_back(refEd(sa[idx], se[idx]));
                hs_edge.push_back(edge_no);
                idx++;
            end
            vis = 0;
            foreach (ed_q[i]) begin
                if (hs_edge[i] <= edge_no - 1) vis += ed_q[i];
            end
            checkOutput("run_sum", 64'(sum_ed), vis);
        end

        if (idx < N) begin
            checkOutput("run_timeout", 64'(idx), 64'(N));
            in_valid = 1'b0;
            return;
        end

        // Keep offering samples: none of these may be consumed.
        in_valid = 1'b1;
        approx   = $urandom;
        exact    = $urandom;
        checkOutput("drain_ready", 64'(in_ready), 64'd0);
        checkOutput("drain_busy", 64'(busy), 64'd1);
        checkOutput("drain_done", 64'(done), 64'd0);

        if (rst_drain) begin
            rst = 1'b1;
            tick();
            rst      = 1'b0;
            in_valid = 1'b0;
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_done", 64'(done), 64'd0);
            checkOutput("rst_ready", 64'(in_ready), 64'd0);
            checkOutput("rst_sum", 64'(sum_ed), 64'd0);
            checkOutput("rst_wce", 64'(wce), 64'd0);
            checkOutput("rst_err", 64'(err_count), 64'd0);
            tick();
            checkOutput("rst_done_hold", 64'(done), 64'd0);
            checkOutput("rst_sum_hold", 64'(sum_ed), 64'd0);
            return;
        end

        tick();
        e_sum = 0;
        e_wce = 0;
        e_err = 0;
        foreach (ed_q[i]) begin
            e_sum += ed_q[i];
            if (ed_q[i] > e_wce) e_wce = ed_q[i];
            if (ed_q[i] != 0) e_err++;
        end
        checkOutput("done_flag", 64'(done), 64'd1);
        checkOutput("done_busy", 64'(busy), 64'd0);
        checkOutput("done_ready", 64'(in_ready), 64'd0);
        checkOutput("done_sum", 64'(sum_ed), e_sum);
        checkOutput("done_med", 64'(med), e_sum / N);
        checkOutput("done_wce", 64'(wce), e_wce);
        checkOutput("done_err", 64'(err_count), 64'(e_err));

        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("hold_done", 64'(done), 64'd1);
        checkOutput("hold_sum", 64'(sum_ed), e_sum);
        checkOutput("hold_err", 64'(err_count), 64'(e_err));
    endtask

    initial begin
        int hs_b;
        int cyc;

        rst        = 1'b1;
        start      = 1'b1;
        in_valid   = 1'b0;
        approx     = '0;
        exact      = '0;
        start_b    = 1'b1;
        in_valid_b = 1'b0;
        approx_b   = '0;
        exact_b    = '0;

        tick();
        tick();
        checkOutput("reset_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_sum", 64'(sum_ed), 64'd0);
        checkOutput("reset_med", 64'(med), 64'd0);
        checkOutput("reset_wce", 64'(wce), 64'd0);
        checkOutput("reset_err", 64'(err_count), 64'd0);
        checkOutput("reset_big_busy", 64'(busy_b), 64'd0);
        rst     = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        tick();
        checkOutput("post_reset_idle", 64'(busy), 64'd0);
        checkOutput("post_reset_ready", 64'(in_ready), 64'd0);

        $display("[TB] directed run");
        sa[0] = 32'd100;        se[0] = 32'd100;
        sa[1] = 32'd90;         se[1] = 32'd100;
        sa[2] = 32'd130;        se[2] = 32'd100;
        sa[3] = 32'hFFFF_FFFF;  se[3] = 32'd0;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("plan_sum", 64'(sum_ed), 64'h1_0000_0027);
        checkOutput("plan_med", 64'(med), 64'h4000_0009);
        checkOutput("plan_wce", 64'(wce), 64'hFFFF_FFFF);
        checkOutput("plan_err", 64'(err_count), 64'd3);

        $display("[TB] equal samples, toggling valid");
        for (int i = 0; i < N; i++) begin
            sa[i] = 32'h1234_5678;
            se[i] = 32'h1234_5678;
        end
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("eq_sum", 64'(sum_ed), 64'd0);
        checkOutput("eq_wce", 64'(wce), 64'd0);
        checkOutput("eq_err", 64'(err_count), 64'd0);

        $display("[TB] start mid-run, then restart from DONE");
        fillSamples(2);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] reset during DRAIN, then fresh run");
        fillSamples(3);
        applyStimulus(2, 1'b0, 1'b1);
        fillSamples(1);
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 12; r++) begin
            fillSamples(int'($urandom_range(0, 3)));
            applyStimulus(int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("[TB] wide instance, all samples at maximum error");
        start_b = 1'b1;
        tick();
        start_b    = 1'b0;
        in_valid_b = 1'b1;
        hs_b       = 0;
        cyc        = 0;
        while (!done_b && cyc < 6000) begin
            if ($urandom_range(0, 1) == 1) begin
                approx_b = 32'hFFFF_FFFF;
                exact_b  = 32'h0;
            end else begin
                approx_b = 32'h0;
                exact_b  = 32'hFFFF_FFFF;
            end
            if (in_ready_b) hs_b++;
            tick();
            cyc++;
        end
        in_valid_b = 1'b0;
        checkOutput("big_done", 64'(done_b), 64'd1);
        checkOutput("big_handshakes", 64'(hs_b), 64'(BN));
        checkOutput("big_sum", 64'(sum_ed_b), 64'(BN) * 64'hFFFF_FFFF);
        checkOutput("big_med", 64'(med_b), 64'hFFFF_FFFF);
        checkOutput("big_wce", 64'(wce_b), 64'hFFFF_FFFF);
        checkOutput("big_err", 64'(err_count_b), 64'(BN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
